// File: rtl/f1_lights_seq.sv
// F1 start-lights sequencer: fills the light bar one light per tick,
// holds for a random number of ticks, then times the driver's reaction.
module f1_lights_seq #(
    parameter int NUM_LIGHTS = 8,
    parameter int TICK_W     = 16,
    parameter int LFSR_W     = 7,
    parameter int TIME_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [TICK_W-1:0]     N,
    input  logic                  trigger,
    input  logic                  stop,
    output logic [NUM_LIGHTS-1:0] data_out,
    output logic                  busy,
    output logic                  react_valid,
    output logic [TIME_W-1:0]     react_time,
    output logic                  false_start
);

    typedef enum logic [1:0] {IDLE, LIGHTS, HOLD, REACT} state_t;

    localparam logic [TIME_W-1:0] TIME_MAX = '1;

    state_t                state, state_nxt;
    logic [TICK_W-1:0]     cnt, cnt_nxt;
    logic [LFSR_W-1:0]     lfsr_q, k_q, k_nxt;
    logic [LFSR_W-1:0]     hold_cnt, hold_nxt, hold_inc;
    logic [TIME_W-1:0]     rcnt, rcnt_nxt, react_time_nxt;
    logic [NUM_LIGHTS-1:0] data_nxt;
    logic                  lfsr_fb, trigger_q, trig_edge, tick, running;
    logic                  valid_nxt, false_nxt;

    // Maximal-length feedback taps per supported width.
    if (LFSR_W == 4) begin : g_tap4
        assign lfsr_fb = lfsr_q[3] ^ lfsr_q[2];
    end else if (LFSR_W == 5) begin : g_tap5
        assign lfsr_fb = lfsr_q[4] ^ lfsr_q[2];
    end else if (LFSR_W == 6) begin : g_tap6
        assign lfsr_fb = lfsr_q[5] ^ lfsr_q[4];
    end else if (LFSR_W == 7) begin : g_tap7
        assign lfsr_fb = lfsr_q[6] ^ lfsr_q[5];
    end else begin : g_tap8
        assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    end

    assign trig_edge = trigger & ~trigger_q;
    assign running   = (state == LIGHTS) || (state == HOLD);
    assign tick      = running && (cnt == '0);
    assign hold_inc  = hold_cnt + 1'b1;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        data_nxt       = data_out;
        k_nxt          = k_q;
        hold_nxt       = hold_cnt;
        rcnt_nxt       = rcnt;
        react_time_nxt = react_time;
        valid_nxt      = 1'b0;
        false_nxt      = 1'b0;

        if (running) begin
            cnt_nxt = tick ? N : cnt - 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (trig_edge) begin
                    state_nxt = LIGHTS;
                    cnt_nxt   = N;
                end
            end
            LIGHTS: begin
                if (stop) begin
                    data_nxt  = '0;
                    false_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (tick) begin
                    data_nxt = {data_out[NUM_LIGHTS-2:0], 1'b1};
                    if (&data_out[NUM_LIGHTS-2:0]) begin
                        state_nxt = HOLD;
                        k_nxt     = lfsr_q;
                        hold_nxt  = '0;
                    end
                end
            end
            HOLD: begin
                if (stop) begin
                    data_nxt  = '0;
                    false_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (hold_inc == k_q) begin
                        data_nxt  = '0;
                        rcnt_nxt  = '0;
                        state_nxt = REACT;
                    end else begin
                        hold_nxt = hold_inc;
                    end
                end
            end
            REACT: begin
                if (stop) begin
                    react_time_nxt = rcnt;
                    valid_nxt      = 1'b1;
                    state_nxt      = IDLE;
                end else if (rcnt == TIME_MAX) begin
                    react_time_nxt = TIME_MAX;
                    valid_nxt      = 1'b1;
                    state_nxt      = IDLE;
                end else begin
                    rcnt_nxt = rcnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lfsr_q      <= LFSR_W'(1);
            trigger_q   <= 1'b0;
            cnt         <= '0;
            data_out    <= '0;
            k_q         <= '0;
            hold_cnt    <= '0;
            rcnt        <= '0;
            react_time  <= '0;
            react_valid <= 1'b0;
            false_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            lfsr_q      <= {lfsr_q[LFSR_W-2:0], lfsr_fb};
            trigger_q   <= trigger;
            cnt         <= cnt_nxt;
            data_out    <= data_nxt;
            k_q         <= k_nxt;
            hold_cnt    <= hold_nxt;
            rcnt        <= rcnt_nxt;
            react_time  <= react_time_nxt;
            react_valid <= valid_nxt;
            false_start <= false_nxt;
            busy        <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_f1_lights_seq.sv
// Bench for f1_lights_seq: vector table for the light fill, scoreboard
// of expected reaction/jump-start pulses, reference LFSR for hold length.
module tb_f1_lights_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] N;
    logic        trigger, stop;
    logic [7:0]  data_out;
    logic        busy, react_valid, false_start;
    logic [15:0] react_time;

    logic [15:0] n2;
    logic        trigger2, stop2;
    logic [1:0]  data_out2;
    logic        busy2, react_valid2, false_start2;
    logic [3:0]  react_time2;

    always #5 clk = ~clk;

    f1_lights_seq dut (
        .clk(clk), .rst(rst), .N(N), .trigger(trigger), .stop(stop),
        .data_out(data_out), .busy(busy), .react_valid(react_valid),
        .react_time(react_time), .false_start(false_start)
    );

    f1_lights_seq #(.NUM_LIGHTS(2), .LFSR_W(4), .TIME_W(4)) dut2 (
        .clk(clk), .rst(rst), .N(n2), .trigger(trigger2), .stop(stop2),
        .data_out(data_out2), .busy(busy2), .react_valid(react_valid2),
        .react_time(react_time2), .false_start(false_start2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_data(input logic [7:0] v, input bit eq,
                             input int lim, input string name);
        int i;
        for (i = 0; i < lim && ((data_out == v) != eq); i++) cyc_wait();
        total++;
        if ((data_out == v) != eq) begin
            bad++;
            $display("FAIL %s: timeout, data_out %0h", name, data_out);
        end
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        cyc_wait();
        trigger = 1'b0;
    endtask

    // Reference 7-bit LFSR, free running from reset like the design's.
    logic [6:0] ref_q;
    always @(posedge clk or posedge rst) begin
        if (rst) ref_q <= 7'h01;
        else     ref_q <= {ref_q[5:0], ref_q[6] ^ ref_q[5]};
    end

    typedef struct {
        logic        is_false;
        logic [15:0] rt;
    } ev_t;
    ev_t sb[$];

    logic [6:0] ref_prev = 7'h01;
    logic [7:0] prev_data = 8'h00;
    logic       pv = 1'b0, pf = 1'b0, in_hold = 1'b0;
    int         hold_len = 0;
    int         hold_exp = 0;
    ev_t        ev;

    always @(negedge clk) begin
        if (rst) begin
            in_hold = 1'b0;
        end else begin
            if (react_valid || false_start) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: valid=%0b false=%0b",
                             react_valid, false_start);
                end else begin
                    ev = sb.pop_front();
                    check("pulse_false", false_start, ev.is_false);
                    check("pulse_valid", react_valid, !ev.is_false);
                    check("react_time", react_time, ev.rt);
                    check("busy_at_pulse", busy, 0);
                end
            end
            if ((react_valid && pv) || (false_start && pf)) begin
                total++;
                bad++;
                $display("FAIL pulse_width: valid=%0b false=%0b",
                         react_valid, false_start);
            end
            if (data_out == 8'hFF && prev_data != 8'hFF) begin
                in_hold  = 1'b1;
                hold_len = 0;
                hold_exp = int'(ref_prev) * (int'(N) + 1);
            end
            if (in_hold) begin
                if (data_out == 8'hFF) begin
                    hold_len++;
                end else begin
                    in_hold = 1'b0;
                    if (!false_start) check("hold_len", hold_len, hold_exp);
                end
            end
        end
        pv        = react_valid;
        pf        = false_start;
        prev_data = data_out;
        ref_prev  = ref_q;
    end

    typedef struct {
        int         off;
        logic [7:0] data;
        logic       busy;
    } vec_t;
    vec_t vecs[$];

    logic [6:0] lfsr_exp[8];
    logic [15:0] last_rt;
    int cur, d;
    logic [7:0] fill;

    initial begin
        lfsr_exp = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};
        vecs.push_back('{off: 0,  data: 8'h00, busy: 1'b0});
        vecs.push_back('{off: 1,  data: 8'h00, busy: 1'b1});
        vecs.push_back('{off: 4,  data: 8'h00, busy: 1'b1});
        vecs.push_back('{off: 5,  data: 8'h01, busy: 1'b1});
        vecs.push_back('{off: 8,  data: 8'h01, busy: 1'b1});
        vecs.push_back('{off: 9,  data: 8'h03, busy: 1'b1});
        vecs.push_back('{off: 13, data: 8'h07, busy: 1'b1});
        vecs.push_back('{off: 17, data: 8'h0F, busy: 1'b1});
        vecs.push_back('{off: 21, data: 8'h1F, busy: 1'b1});
        vecs.push_back('{off: 25, data: 8'h3F, busy: 1'b1});
        vecs.push_back('{off: 29, data: 8'h7F, busy: 1'b1});
        vecs.push_back('{off: 32, data: 8'h7F, busy: 1'b1});
        vecs.push_back('{off: 33, data: 8'hFF, busy: 1'b1});

        rst = 1'b1;
        N = 16'd3;
        trigger = 1'b0;
        stop = 1'b0;
        n2 = 16'd0;
        trigger2 = 1'b0;
        stop2 = 1'b0;
        last_rt = 16'd0;
        #3;
        check("rst_data", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", react_valid, 0);
        check("rst_time", react_time, 0);
        check("rst_false", false_start, 0);
        check("rst_busy2", busy2, 0);
        cyc_wait();
        cyc_wait();
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            check("lfsr_seq", dut.lfsr_q, lfsr_exp[i]);
            cyc_wait();
        end

        for (int i = 0; i < 6; i++) begin
            stop = ~stop;
            cyc_wait();
            check("idle_stop_pulse", {react_valid, false_start, busy}, 0);
        end
        stop = 1'b0;
        cyc_wait();

        // Light fill, N=3.
        trigger = 1'b1;
        cur = 0;
        foreach (vecs[i]) begin
            while (cur < vecs[i].off) begin
                cyc_wait();
                trigger = 1'b0;
                cur++;
            end
            check($sformatf("fill_data@%0d", cur), data_out, vecs[i].data);
            check($sformatf("fill_busy@%0d", cur), busy, vecs[i].busy);
        end

        // Reaction of 37 cycles.
        wait_data(8'hFF, 1'b0, 600, "hold_end");
        repeat (37) cyc_wait();
        check("react_idle_pre", react_valid, 0);
        stop = 1'b1;
        sb.push_back('{is_false: 1'b0, rt: 16'd37});
        last_rt = 16'd37;
        cyc_wait();
        stop = 1'b0;
        check("react37_valid", react_valid, 1);
        check("react37_time", react_time, 37);
        check("react37_busy", busy, 0);
        cyc_wait();
        check("react37_drop", react_valid, 0);

        // Jump start at 0x07, then restart.
        pulse_trigger();
        wait_data(8'h07, 1'b1, 100, "reach_07");
        stop = 1'b1;
        sb.push_back('{is_false: 1'b1, rt: last_rt});
        cyc_wait();
        stop = 1'b0;
        check("jump_data", data_out, 0);
        check("jump_false", false_start, 1);
        check("jump_busy", busy, 0);
        cyc_wait();
        check("jump_drop", false_start, 0);
        pulse_trigger();
        check("restart_busy", busy, 1);

        // Reset during HOLD.
        wait_data(8'hFF, 1'b1, 100, "reach_hold");
        cyc_wait();
        #2 rst = 1'b1;
        #1;
        check("hold_rst_data", data_out, 0);
        check("hold_rst_busy", busy, 0);
        check("hold_rst_time", react_time, 0);
        check("hold_rst_pulse", {react_valid, false_start}, 0);
        last_rt = 16'd0;
        cyc_wait();
        rst = 1'b0;
        repeat (3) begin
            cyc_wait();
            check("post_rst_quiet", {react_valid, false_start, busy}, 0);
        end

        // Random hold lengths with random reaction delays.
        for (int r = 0; r < 20; r++) begin
            pulse_trigger();
            wait_data(8'hFF, 1'b1, 100, "rnd_fill");
            wait_data(8'hFF, 1'b0, 600, "rnd_hold");
            d = $urandom_range(0, 20);
            repeat (d) cyc_wait();
            stop = 1'b1;
            sb.push_back('{is_false: 1'b0, rt: 16'(d)});
            last_rt = 16'(d);
            cyc_wait();
            stop = 1'b0;
            cyc_wait();
        end

        // Trigger held across a whole run.
        trigger = 1'b1;
        wait_data(8'hFF, 1'b1, 100, "held_fill");
        wait_data(8'hFF, 1'b0, 600, "held_hold");
        repeat (5) cyc_wait();
        stop = 1'b1;
        sb.push_back('{is_false: 1'b0, rt: 16'd5});
        last_rt = 16'd5;
        cyc_wait();
        stop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("held_no_restart", busy, 0);
            cyc_wait();
        end
        trigger = 1'b0;
        cyc_wait();

        // N=0: one light per cycle, jump start on first HOLD cycle.
        N = 16'd0;
        trigger = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            cyc_wait();
            trigger = 1'b0;
            fill = 8'((9'd1 << (j - 1)) - 9'd1);
            check($sformatf("n0_fill@%0d", j), data_out, fill);
        end
        stop = 1'b1;
        sb.push_back('{is_false: 1'b1, rt: last_rt});
        cyc_wait();
        stop = 1'b0;
        check("n0_jump_data", data_out, 0);
        cyc_wait();
        N = 16'd3;

        // 4-bit reaction counter saturates without stop.
        trigger2 = 1'b1;
        cyc_wait();
        trigger2 = 1'b0;
        for (int i = 0; i < 200 && !react_valid2; i++) cyc_wait();
        check("sat_valid", react_valid2, 1);
        check("sat_time", react_time2, 15);
        check("sat_busy", busy2, 0);
        check("sat_false", false_start2, 0);
        cyc_wait();
        check("sat_drop", react_valid2, 0);

        repeat (3) cyc_wait();
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/f1_lights_seq.md
# f1_lights_seq

Parametrised F1 start-lights sequencer with reaction-time measurement. It is the single-module successor to the tick/LFSR/delay/FSM light chain. It fills a configurable bank of lights one per tick, then holds them all on for a pseudo-random number of ticks and extinguishes them. It then counts clock cycles until the driver's `stop` input, reports jump starts, and sits directly between the board inputs (switch, button, tick period) and the light bar / display logic.

## Interface
- `NUM_LIGHTS`, 8, number of lights; must be ≥2
- `TICK_W`, 16, width of tick period input `N`
- `LFSR_W`, 7, random-delay LFSR width; supported values are 4..8
- `TIME_W`, 16, width of reaction-time counter
- `clk` in 1 — single clock, all logic on rising edge
- `rst` in 1 — asynchronous, active-high reset
- `N` in TICK_W — tick period minus one; tick fires every N+1 cycles
- `trigger` in 1 — start request; a rising edge is detected internally
- `stop` in 1 — driver button, level-sampled
- `data_out` out NUM_LIGHTS — light bar; bit 0 is the first light
- `busy` out 1 — high in any state other than IDLE
- `react_valid` out 1 — one-cycle pulse when `react_time` is updated
- `react_time` out TIME_W — last measured reaction, held until the next update
- `false_start` out 1 — one-cycle pulse on a jump start

## Operation
- States are IDLE, LIGHTS, HOLD and REACT.
- **Tick generator:** `cnt` is loaded with `N` on entry to LIGHTS. In LIGHTS and HOLD it decrements each cycle. When `cnt==0`, an internal `tick` is asserted and `cnt` reloads `N`. The counter is frozen in IDLE and REACT. `N=0` gives a tick every cycle. `N` is sampled at each reload.
- **LFSR:** Fibonacci, seed 1, advances every cycle in all states, and is never zero. Update is `q <= {q[LFSR_W-2:0], fb}`.
- **LFSR feedback taps per width:**
  - 4: `q3^q2`
  - 5: `q4^q2`
  - 6: `q5^q4`
  - 7: `q6^q5`
  - 8: `q7^q5^q4^q3`
- **IDLE:** on a `trigger` rising edge (`trigger & ~trigger_q`), go to LIGHTS. `data_out` stays 0.
- **LIGHTS:** on each tick, `data_out <= {data_out[NUM_LIGHTS-2:0],1'b1}`. The tick that makes `data_out` all ones transitions to HOLD. On that transition, latch `K <= q` (range 1..2^LFSR_W-1) and clear `hold_cnt`.
- **HOLD:** `hold_cnt` increments per tick. On the tick where `hold_cnt+1==K`:
  - set `data_out <= 0`;
  - clear `rcnt`;
  - go to REACT.
- **REACT:** `rcnt` increments every cycle that `stop` is low, saturating at all-ones. When `stop` is high, `react_time <= rcnt`, `react_valid` pulses, and the FSM returns to IDLE.
  - If `rcnt` reaches all-ones, the FSM also returns to IDLE, with `react_time` = all-ones and a `react_valid` pulse.
- **Jump start:** `stop` high in any cycle in LIGHTS or HOLD causes the following, and takes priority over a coincident tick:
  - `data_out <= 0`;
  - `false_start` pulses;
  - the FSM returns to IDLE;
  - `react_time` is unchanged.
- `trigger` edges while `busy` are ignored. The edge detector still tracks, so a level held through the return to IDLE does not restart.
- **Reset:** all outputs reset to 0, state goes to IDLE, LFSR to 1, all counters to 0, and `trigger_q` to 0. Asserting reset mid-sequence aborts immediately with no pulse.

## Timing
- All outputs are registered.
- Trigger edge sampled in cycle t → `busy` high from t+1.
- First light is on at t+1+N+1 (i.e. after N+1 cycles in LIGHTS). Each further light follows N+1 cycles later.
- HOLD duration is exactly K·(N+1) cycles. `data_out` clears on the edge of the K-th HOLD tick.
- `stop` high in the first REACT cycle gives `react_time=0`. In general, `react_time` equals the number of REACT cycles before the `stop` cycle.
- `react_valid`/`false_start` go high in the cycle after the sampling cycle, together with `busy` low.
- Only one of `react_valid`/`false_start` is asserted per run.
- The next trigger is accepted from the first IDLE cycle.

## Test plan
- **Reset/idle:** assert `rst` async mid-clock → all outputs 0 immediately; toggle `stop` in IDLE → no pulses.
- **Light fill:** NUM_LIGHTS=8, N=3, trigger edge at cycle 10 → `data_out` goes 0x01,0x03,…,0xFF at cycles 15,19,…,43; `busy` high from cycle 11.
- **Random hold:** repeat 20 runs with a reference LFSR model → HOLD length = K·4 cycles with 1≤K≤127. Independently check the first LFSR states from reset: 01,02,04,08,10,20,41,03.
- **Reaction:** `stop` raised 37 cycles after `data_out`→0 → `react_time=37`, one-cycle `react_valid`, `busy` low the same cycle.
- **Jump start:** `stop` high when `data_out`=0x07 → `data_out`=0, `false_start` one-cycle pulse, `react_time` keeps its previous value; a trigger edge then restarts cleanly.
- **Boundaries:**
  - N=0 fills one light per cycle.
  - TIME_W=4 with no `stop` → `react_time`=15 with `react_valid`.
  - Trigger held high across a whole run → no second start.
  - `rst` during HOLD → IDLE with no pulse.
